// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the key event generator.
// Imported by the per-key channel and the top level.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } key_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int d, input int r);
    int top;
    top = ((d > r) ? d : r) - 1;
    return (top > 1) ? $clog2(top + 1) : 1;
  endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Valid/ready event channel carrying a key index and repeat flag.
// Master is the event source, slave the consumer.
interface key_event_if #(
  parameter int KW = 2
);

  logic          ev_valid;
  logic          ev_ready;
  logic [KW-1:0] ev_key;
  logic          ev_repeat;

  modport master (
    output ev_valid,
    output ev_key,
    output ev_repeat,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_key,
    input  ev_repeat,
    output ev_ready
  );

endinterface

// File: rtl/key_repeat_channel.sv
// One key: edge detect, IDLE/DELAY/REPEAT FSM, hold counter,
// and the pending/repeat bits drained by the top-level arbiter.
module key_repeat_channel
  import key_event_pkg::*;
#(
  parameter int DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed_i,
  input  logic pop_i,
  output logic pend_o,
  output logic rep_o,
  output logic drop_o
);

  localparam int CW = cnt_width(DELAY_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DLY_END = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RPT_END = CW'(REPEAT_CYCLES - 1);

  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          pend_q, pend_d;
  logic          rep_q, rep_d;
  logic          set, set_rep;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set     = 1'b0;
    set_rep = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed_i && !prev_q) begin
          state_d = DELAY;
          cnt_d   = '0;
          set     = 1'b1;
        end
      end
      DELAY: begin
        if (!pressed_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_END) begin
          state_d = REPEAT;
          cnt_d   = '0;
          set     = 1'b1;
          set_rep = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!pressed_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RPT_END) begin
          cnt_d   = '0;
          set     = 1'b1;
          set_rep = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new event on an undrained slot is dropped; a same-cycle pop frees it.
  always_comb begin
    pend_d = pend_q;
    rep_d  = rep_q;
    drop_o = 1'b0;
    if (set) begin
      if (pend_q && !pop_i) begin
        drop_o = 1'b1;
      end else begin
        pend_d = 1'b1;
        rep_d  = set_rep;
      end
    end else if (pop_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= pressed_i;
      pend_q  <= pend_d;
      rep_q   <= rep_d;
    end
  end

  assign pend_o = pend_q;
  assign rep_o  = rep_q;

endmodule

// File: rtl/key_event_gen.sv
// Key press / auto-repeat event generator: per-key channels,
// lowest-index arbiter and a registered valid/ready output.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  key_event_if.master       ev,
  output logic [N_KEYS-1:0] held,
  output logic              overrun
);

  localparam int KW = idx_width(N_KEYS);

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] pend, rep, drop, pop;
  logic [N_KEYS-1:0] held_q;
  logic [KW-1:0]     sel, key_q;
  logic              any, load;
  logic              valid_q, rep_q, overrun_q;

  assign pressed = keys_in ^ {N_KEYS{ACTIVE_LOW}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_repeat_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pressed_i(pressed[g]),
      .pop_i    (pop[g]),
      .pend_o   (pend[g]),
      .rep_o    (rep[g]),
      .drop_o   (drop[g])
    );
  end

  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any = 1'b1;
        sel = KW'(i);
      end
    end
  end

  // Lowest set bit of pend is the granted key.
  assign load = !valid_q || ev.ev_ready;
  assign pop  = load ? (pend & (~pend + 1'b1)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      key_q     <= '0;
      rep_q     <= 1'b0;
      held_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      held_q    <= pressed;
      overrun_q <= |drop;
      if (load) begin
        valid_q <= any;
        if (any) begin
          key_q <= sel;
          rep_q <= |(rep & pop);
        end
      end
    end
  end

  assign ev.ev_valid  = valid_q;
  assign ev.ev_key    = key_q;
  assign ev.ev_repeat = rep_q;
  assign held         = held_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen against an age-based
// reference model of press/repeat events, queueing and arbitration.
module tb_key_event_gen;

  localparam int N = 4;
  localparam int D = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] keys = '1;
  logic [N-1:0] held;
  logic         overrun;

  key_event_if #(.KW(2)) ev_if ();

  always #5 clk = ~clk;

  key_event_gen #(
    .N_KEYS       (N),
    .ACTIVE_LOW   (1'b1),
    .DELAY_CYCLES (D),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .keys_in(keys),
    .ev     (ev_if),
    .held   (held),
    .overrun(overrun)
  );

  int checks = 0;
  int fails = 0;

  int           age [N];
  bit [N-1:0]   m_pend, m_rep, m_prev, m_held;
  bit           m_valid, m_rep_o, m_ovr;
  int           m_key;

  int acc_key[$];
  bit acc_rep[$];
  int n_ovr;

  task automatic m_reset();
    for (int i = 0; i < N; i++) age[i] = -1;
    m_pend = '0; m_rep = '0; m_prev = '0; m_held = '0;
    m_valid = 0; m_rep_o = 0; m_ovr = 0; m_key = 0;
  endtask

  task automatic clr_log();
    acc_key.delete();
    acc_rep.delete();
    n_ovr = 0;
  endtask

  // One clock: log handshake, advance the model on the edge, settle.
  task automatic cyc();
    bit [N-1:0] p, gen, grep;
    int sel;
    bit ld;
    if (ev_if.ev_valid && ev_if.ev_ready) begin
      acc_key.push_back(int'(ev_if.ev_key));
      acc_rep.push_back(ev_if.ev_repeat);
    end
    if (overrun) n_ovr++;
    @(posedge clk);
    p = ~keys;
    ld = !m_valid || ev_if.ev_ready;
    sel = -1;
    if (ld) for (int i = N - 1; i >= 0; i--) if (m_pend[i]) sel = i;
    gen = '0; grep = '0;
    for (int i = 0; i < N; i++) begin
      if (age[i] < 0) begin
        if (p[i] && !m_prev[i]) begin gen[i] = 1; age[i] = 0; end
      end else if (!p[i]) begin
        age[i] = -1;
      end else begin
        age[i]++;
        if (age[i] >= D && (age[i] - D) % R == 0) begin
          gen[i] = 1; grep[i] = 1;
        end
      end
    end
    if (ld) begin
      m_valid = (sel >= 0);
      if (sel >= 0) begin m_key = sel; m_rep_o = m_rep[sel]; end
    end
    m_ovr = 0;
    for (int i = 0; i < N; i++) begin
      if (gen[i]) begin
        if (m_pend[i] && sel != i) m_ovr = 1;
        else begin m_pend[i] = 1; m_rep[i] = grep[i]; end
      end else if (sel == i) begin
        m_pend[i] = 0;
      end
    end
    m_prev = p;
    m_held = p;
    #1;
  endtask

  task automatic test_reset();
    ev_if.ev_ready = 1'b1;
    keys = '1;
    #1 reset = 1'b1;
    #3;
    checks++;
    if ({ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun} !== 9'd0)
      begin fails++; $display("FAIL reset: outputs=%b required all 0",
        {ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun}); end
    @(negedge clk) reset = 1'b0;
    m_reset();
  endtask

  task automatic test_tap();
    int nv = 0;
    clr_log();
    ev_if.ev_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      keys = (c < 3) ? 4'b1101 : 4'b1111;
      cyc();
      if (ev_if.ev_valid) nv++;
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL tap c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
    checks++;
    if (nv != 1 || acc_key.size() != 1 || acc_key[0] != 1 || acc_rep[0] != 0)
      begin fails++; $display("FAIL tap_events: valid_cycles=%0d events=%0d, required 1 and 1 {key1,rep0}",
        nv, acc_key.size()); end
  endtask

  task automatic test_hold();
    clr_log();
    ev_if.ev_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      keys = (c < 20) ? 4'b1011 : 4'b1111;
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL hold c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
    checks++;
    if (acc_key.size() != 4 || acc_rep[0] != 0 || acc_rep[1] != 1 ||
        acc_rep[2] != 1 || acc_rep[3] != 1 || acc_key[3] != 2)
      begin fails++; $display("FAIL hold_events: got %0d events, required 4 (press + 3 repeats on key 2)",
        acc_key.size()); end
  endtask

  task automatic test_contention();
    clr_log();
    ev_if.ev_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      keys = (c < 3) ? 4'b0110 : 4'b1111;
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL contention c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
    checks++;
    if (acc_key.size() != 2 || acc_key[0] != 0 || acc_key[1] != 3)
      begin fails++; $display("FAIL contention_order: events=%0d first=%0d second=%0d, required 2 events keys 0 then 3",
        acc_key.size(), acc_key[0], acc_key[1]); end
  endtask

  task automatic test_backpressure();
    clr_log();
    for (int c = 0; c < 26; c++) begin
      keys = (c < 14) ? 4'b1110 : 4'b1111;
      ev_if.ev_ready = (c >= 14);
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL backpressure c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
    checks++;
    if (n_ovr != 1 || acc_key.size() != 2 || acc_rep[0] != 0 || acc_rep[1] != 1)
      begin fails++; $display("FAIL backpressure_drain: overruns=%0d events=%0d, required 1 overrun and press+repeat",
        n_ovr, acc_key.size()); end
  endtask

  task automatic test_release_race();
    clr_log();
    for (int c = 0; c < 20; c++) begin
      keys = (c < 1) ? 4'b1011 : 4'b1111;
      ev_if.ev_ready = (c >= 6);
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL release_race c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
    checks++;
    if (acc_key.size() != 1 || acc_key[0] != 2 || acc_rep[0] != 0)
      begin fails++; $display("FAIL release_race_events: events=%0d, required 1 {key2,rep0}",
        acc_key.size()); end
  endtask

  task automatic test_reset_mid_hold();
    clr_log();
    ev_if.ev_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      keys = 4'b1101;
      cyc();
    end
    checks++;
    if (ev_if.ev_valid !== 1'b1)
      begin fails++; $display("FAIL mid_hold_pre: ev_valid=%b required 1", ev_if.ev_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun} !== 9'd0)
      begin fails++; $display("FAIL mid_hold_reset: outputs=%b required all 0",
        {ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun}); end
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    m_reset();
    ev_if.ev_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      keys = (c < 5) ? 4'b1101 : 4'b1111;
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL mid_hold c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
      if (c == 1) begin
        checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_key !== 2'd1 || ev_if.ev_repeat !== 1'b0)
          begin fails++; $display("FAIL mid_hold_fresh: v=%b k=%0d r=%b, required v=1 k=1 r=0",
            ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) keys[i] = ~keys[i];
        ev_if.ev_ready = ($urandom_range(0, 3) != 0);
      end else begin
        keys = '1;
        ev_if.ev_ready = 1'b1;
      end
      cyc();
      checks++;
      if (ev_if.ev_valid !== m_valid || held !== m_held || overrun !== m_ovr ||
          (m_valid && (ev_if.ev_key !== 2'(m_key) || ev_if.ev_repeat !== m_rep_o)))
        begin fails++; $display("FAIL random c=%0d: v=%b k=%0d r=%b h=%b o=%b, required v=%b k=%0d r=%b h=%b o=%b",
          c, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_repeat, held, overrun,
          m_valid, m_key, m_rep_o, m_held, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold();
    test_contention();
    test_backpressure();
    test_release_race();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
